// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Parametrised register file with NUM_RD independent read ports and one
//   byte-enabled write port. Reads are combinational (RD_LATENCY=0) or
//   registered with write-first bypass (RD_LATENCY=1). Entry 0 can be
//   hard-wired to zero (ZERO_REG=1). A background clear engine sweeps every
//   entry back to RST_VALUE, one entry per cycle, without using reset.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   rd_addr_i  : NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data_o  : NUM_RD packed read words,     port p at [p*DATA_W +: DATA_W]
//   wr_en_i    : write request (dropped while the sweep runs)
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   wr_be_i    : byte enables, bit b gates byte [8b+7:8b]
//   clr_req_i  : single-cycle request to start the clear sweep
//   busy_o     : high while the clear sweep runs
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 6,
    parameter int                NUM_RD     = 2,
    parameter int                RD_LATENCY = 0,
    parameter int                ZERO_REG   = 0,
    parameter logic [DATA_W-1:0] RST_VALUE  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [DATA_W/8-1:0]      wr_be_i,
    input  logic                     clr_req_i,
    output logic                     busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   wr_mask;
    logic [DATA_W-1:0]   wr_word;
    logic                wr_accept;

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Counter wraps to 0 on the edge that clears the last entry.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == CLEAR);

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mask
            assign wr_mask[gi*8 +: 8] = {8{wr_be_i[gi]}};
        end
    endgenerate

    // Writes are only taken while idle; entry 0 is read-only when hard-wired.
    assign wr_accept = wr_en_i && (state_q == IDLE) &&
                       !((ZERO_REG != 0) && (wr_addr_i == '0));

    assign wr_word = (mem_q[wr_addr_i] & ~wr_mask) | (wr_data_i & wr_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VALUE;
            end
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= RST_VALUE;
        end else if (wr_accept) begin
            mem_q[wr_addr_i] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] mem_word;
            logic              is_zero;

            assign addr     = rd_addr_i[gi*ADDR_W +: ADDR_W];
            assign mem_word = mem_q[addr];
            assign is_zero  = (ZERO_REG != 0) && (addr == '0);

            if (RD_LATENCY == 0) begin : g_comb
                assign rd_data_o[gi*DATA_W +: DATA_W] = is_zero ? '0 : mem_word;
            end else begin : g_reg
                logic [DATA_W-1:0] rd_q, rd_d;

                // Write-first: enabled bytes of a same-edge write to this
                // address are forwarded. The sweep is deliberately not
                // forwarded, so a read of the entry being cleared sees the
                // old value.
                always_comb begin
                    rd_d = mem_word;
                    if (wr_accept && (wr_addr_i == addr)) begin
                        rd_d = (mem_word & ~wr_mask) | (wr_data_i & wr_mask);
                    end
                    if (is_zero) begin
                        rd_d = '0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        rd_q <= '0;
                    end else begin
                        rd_q <= rd_d;
                    end
                end

                assign rd_data_o[gi*DATA_W +: DATA_W] = rd_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Two instances: dut_a (64 entries, combinational reads, RST=DEADBEEF) and
//   dut_b (16 entries, registered reads, zero register, RST=A5A50F0F).
//   Expected read values come from a per-instance model memory and are
//   queued when a read is issued, then popped when the data is valid.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    localparam logic [31:0] RST_A = 32'hDEAD_BEEF;
    localparam logic [31:0] RST_B = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic        rst_n_a;
    logic [11:0] rd_addr_a;
    logic [63:0] rd_data_a;
    logic        wr_en_a;
    logic [5:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [3:0]  wr_be_a;
    logic        clr_req_a;
    logic        busy_a;

    // dut_b signals
    logic        rst_n_b;
    logic [7:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        wr_en_b;
    logic [3:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [3:0]  wr_be_b;
    logic        clr_req_b;
    logic        busy_b;

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(6), .NUM_RD(2), .RD_LATENCY(0),
        .ZERO_REG(0), .RST_VALUE(RST_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a),
        .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
        .wr_be_i(wr_be_a), .clr_req_i(clr_req_a), .busy_o(busy_a)
    );

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(4), .NUM_RD(2), .RD_LATENCY(1),
        .ZERO_REG(1), .RST_VALUE(RST_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b),
        .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
        .wr_be_i(wr_be_b), .clr_req_i(clr_req_b), .busy_o(busy_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_a [64];
    logic [31:0] model_b [16];
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end else begin
            $display("ok   %s got %h", tag, got);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_b(input logic [3:0] a);
        return (a == 4'd0) ? 32'h0 : model_b[a];
    endfunction

    // ---------------- dut_a helpers (called at a negedge) ----------------
    task automatic a_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d; wr_be_a = be;
        @(negedge clk);
        wr_en_a = 1'b0;
        model_a[a] = merge(model_a[a], d, be);
    endtask

    task automatic a_read_exp(input logic [5:0] a0, input logic [5:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] e;
        rd_addr_a = {a1, a0};
        sb_q.push_back(e0);
        sb_q.push_back(e1);
        #1;
        e = sb_q.pop_front();
        check($sformatf("a_rd0[%0d]", a0), rd_data_a[31:0], e);
        e = sb_q.pop_front();
        check($sformatf("a_rd1[%0d]", a1), rd_data_a[63:32], e);
        @(negedge clk);
    endtask

    task automatic a_read(input logic [5:0] a0, input logic [5:0] a1);
        a_read_exp(a0, a1, model_a[a0], model_a[a1]);
    endtask

    // ---------------- dut_b helpers (called at a negedge) ----------------
    task automatic b_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d; wr_be_b = be;
        @(negedge clk);
        wr_en_b = 1'b0;
        if (a != 4'd0) model_b[a] = merge(model_b[a], d, be);
    endtask

    task automatic b_read_exp(input logic [3:0] a0, input logic [3:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] e;
        rd_addr_b = {a1, a0};
        sb_q.push_back(e0);
        sb_q.push_back(e1);
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("b_rd0[%0d]", a0), rd_data_b[31:0], e);
        e = sb_q.pop_front();
        check($sformatf("b_rd1[%0d]", a1), rd_data_b[63:32], e);
    endtask

    task automatic b_read(input logic [3:0] a0, input logic [3:0] a1);
        b_read_exp(a0, a1, exp_b(a0), exp_b(a1));
    endtask

    task automatic b_read_all();
        for (int i = 0; i < 16; i += 2) begin
            b_read(4'(i), 4'(i + 1));
        end
    endtask

    task automatic b_fill(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) begin
            b_write(4'(i), seed * 32'(i + 1), 4'hF);
        end
    endtask

    // Pulses clr_req and counts the negedges at which busy is seen high.
    // wr_at: busy count at which a write to address 3 is attempted.
    // rst_at: busy count at which reset is asserted (returns at the negedge
    // after the reset edge, with rst_n_b still low).
    task automatic b_sweep(input int rst_at, input int wr_at, output int cnt);
        clr_req_b = 1'b1;
        @(negedge clk);
        clr_req_b = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy_b) break;
            cnt++;
            wr_en_b   = (cnt == wr_at);
            wr_addr_b = 4'd3;
            wr_data_b = 32'hFFFF_FFFF;
            wr_be_b   = 4'hF;
            clr_req_b = (cnt == 2);     // must be ignored mid-sweep
            rst_n_b   = (cnt != rst_at);
            @(negedge clk);
            if (cnt == rst_at) break;
        end
        wr_en_b   = 1'b0;
        clr_req_b = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [5:0]  ra;
        logic [31:0] rdat;
        logic [3:0]  rbe;

        rst_n_a = 1'b0; rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0;
        wr_data_a = '0; wr_be_a = '0; clr_req_a = 1'b0;
        rst_n_b = 1'b0; rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0;
        wr_data_b = '0; wr_be_b = '0; clr_req_b = 1'b0;

        // One reset edge, then check reset state.
        @(negedge clk);
        check("a_busy_rst", {31'b0, busy_a}, 32'h0);
        check("b_busy_rst", {31'b0, busy_b}, 32'h0);
        check("b_rd0_rst",  rd_data_b[31:0],  32'h0);
        check("b_rd1_rst",  rd_data_b[63:32], 32'h0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        for (int i = 0; i < 64; i++) model_a[i] = RST_A;
        for (int i = 0; i < 16; i++) model_b[i] = RST_B;

        // ---------------- dut_a: combinational reads ----------------
        a_read_exp(6'd5, 6'd63, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        a_write(6'd7, 32'h1122_3344, 4'hF);
        a_write(6'd7, 32'hAABB_CCDD, 4'b0101);
        a_read_exp(6'd7, 6'd5, 32'h11BB_33DD, 32'hDEAD_BEEF);

        a_write(6'd7, 32'h0000_0000, 4'h0);            // be=0 is a no-op
        a_read_exp(6'd7, 6'd7, 32'h11BB_33DD, 32'h11BB_33DD);

        // Same-cycle write is not visible until after the edge.
        wr_en_a = 1'b1; wr_addr_a = 6'd20; wr_data_a = 32'h0BAD_F00D; wr_be_a = 4'hF;
        rd_addr_a = {6'd20, 6'd20};
        sb_q.push_back(RST_A);
        #1;
        check("a_same_cycle", rd_data_a[31:0], sb_q.pop_front());
        @(negedge clk);
        wr_en_a = 1'b0;
        model_a[20] = merge(model_a[20], 32'h0BAD_F00D, 4'hF);
        a_read_exp(6'd20, 6'd21, 32'h0BAD_F00D, RST_A);

        for (int i = 0; i < 6; i++) begin
            ra   = 6'($urandom_range(1, 63));
            rdat = $urandom;
            rbe  = 4'($urandom_range(0, 15));
            a_write(ra, rdat, rbe);
            a_read(ra, ra ^ 6'd1);
        end

        // ---------------- dut_b: registered reads, zero reg ----------------
        b_write(4'd9, 32'h1234_5678, 4'hF);
        wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 32'h0000_00FF; wr_be_b = 4'h1;
        model_b[9] = merge(model_b[9], 32'h0000_00FF, 4'h1);
        rd_addr_b = {4'd9, 4'd9};
        sb_q.push_back(32'h1234_56FF);
        sb_q.push_back(32'h1234_56FF);
        @(negedge clk);
        wr_en_b = 1'b0;
        check("b_bypass0", rd_data_b[31:0],  sb_q.pop_front());
        check("b_bypass1", rd_data_b[63:32], sb_q.pop_front());

        b_write(4'd1, 32'h0101_CAFE, 4'hF);
        b_write(4'd0, 32'hFFFF_FFFF, 4'hF);
        b_read_exp(4'd0, 4'd1, 32'h0, 32'h0101_CAFE);

        // Write to entry 0 with a same-edge read of it: still zero.
        wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = 32'h1357_9BDF; wr_be_b = 4'hF;
        b_read_exp(4'd0, 4'd9, 32'h0, 32'h1234_56FF);
        wr_en_b = 1'b0;

        // Full sweep with a dropped write and an ignored clr_req.
        b_fill(32'h0101_0101);
        b_read(4'd3, 4'd15);
        b_sweep(0, 6, cnt);
        check("b_sweep_len", 32'(cnt), 32'd16);
        check("b_busy_done", {31'b0, busy_b}, 32'h0);
        for (int i = 0; i < 16; i++) model_b[i] = RST_B;
        b_read_all();

        // Reset at sweep cycle 5 aborts the sweep.
        b_fill(32'h0202_0303);
        b_sweep(5, 0, cnt);
        check("b_rst_at", 32'(cnt), 32'd5);
        check("b_busy_rst_mid", {31'b0, busy_b}, 32'h0);
        rst_n_b = 1'b1;
        for (int i = 0; i < 16; i++) model_b[i] = RST_B;
        b_read_all();

        // New sweeps complete normally, second one issued on the first idle cycle.
        b_fill(32'h0404_0505);
        b_sweep(0, 0, cnt);
        check("b_sweep2_len", 32'(cnt), 32'd16);
        b_sweep(0, 0, cnt);
        check("b_sweep3_len", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) model_b[i] = RST_B;
        b_read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
